dual_port_fifo_ctrl: RTL
========================

// Module: dual_port_fifo_ctrl
// PURPOSE
//  Initiator side of the dual_port RAM: turns a streaming valid/ready producer
//  and consumer into RAM write/read commands. Owns write/read pointers, occupancy
//  and a 2-entry output buffer that absorbs the RAM's 1-cycle registered read
//  latency, so the consumer side sustains 1 word/cycle. Sits between the datapath
//  and one dual_port instance on the same clk.
// PARAMETERS
//  WIDTH      8    data word width; must match the RAM WIDTH
//  DEPTH      128  RAM entries; must equal 2**ADD_WIDTH
//  ADD_WIDTH  7    RAM address width
//  LVL_W      ADD_WIDTH+2  width of level (local, derived)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          synchronous, active-high reset
//  s_valid      in   1          producer word valid
//  s_ready      out  1          controller can accept a word
//  s_data       in   WIDTH      producer word
//  m_valid      out  1          m_data valid
//  m_ready      in   1          consumer accepts m_data
//  m_data       out  WIDTH      head word (oldest)
//  mem_wr_en    out  1          RAM write enable
//  mem_wr_addr  out  ADD_WIDTH  RAM write address
//  mem_wdata    out  WIDTH      RAM write data
//  mem_rd_en    out  1          RAM read enable
//  mem_rd_addr  out  ADD_WIDTH  RAM read address
//  mem_rdata    in   WIDTH      RAM rdata, valid cycle after mem_rd_en
//  level        out  LVL_W      total words held (RAM + in flight + out buffer)
//  full         out  1          level == DEPTH+2
//  empty        out  1          level == 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr, rd_ptr, mem_cnt, inflight, out buffer, level
//    -> 0; m_valid=0, empty=1, full=0. s_ready=0, mem_wr_en=0, mem_rd_en=0 while
//    rst is high. Reset mid-stream discards all held/in-flight data; a mem_rdata
//    returning the cycle after reset is ignored.
//  - Push: s_valid && s_ready -> mem_wr_en=1, mem_wr_addr=wr_ptr, mem_wdata=s_data
//    combinationally; wr_ptr++ (wraps 127->0), mem_cnt++ at edge.
//  - s_ready = !rst && (mem_cnt < DEPTH); pop does not relieve this in same cycle.
//  - Read issue: mem_rd_en=1 when mem_cnt>0 && (out_cnt + inflight) < 2, with
//    out_cnt sampled after this cycle's m_ready pop; mem_rd_addr=rd_ptr; rd_ptr++,
//    mem_cnt--, inflight=1 at edge. Never reads an entry written this cycle
//    (mem_cnt counts committed words only), so RAM read/write collisions are
//    impossible.
//  - Return: cycle after mem_rd_en, mem_rdata pushed into out buffer tail;
//    inflight->0.
//  - Pop: m_valid = out_cnt>0; m_data = buffer head; m_valid && m_ready pops.
//    Same-cycle pop and return: both apply, order preserved.
//  - Latency: word accepted in cycle N (empty FIFO) -> m_valid in cycle N+3.
//  - level: +1 on push, -1 on pop, unchanged on both; registered.
//  - Steady push+pop every cycle: no bubbles after initial latency.
//  - Capacity DEPTH+2 (130 default). Order strictly FIFO across pointer wrap.
// STRUCTURE
//  - dual_port_pkg: WIDTH/DEPTH/ADD_WIDTH defaults, LVL_W, shared by dual_port
//    and this block.
//  - Sub-module fifo_out_buf: 2-entry in-order buffer (push, pop, cnt, head).
//  - Top: pointer/count logic, read-issue logic, level/flags.
// TESTING
//  1 Reset then idle: empty=1, level=0, m_valid=0, mem_wr_en=mem_rd_en=0.
//  2 Push 0x00..0x81 (130 words), m_ready=0 -> s_ready low after 130th accept,
//    full=1, level=130; then m_ready=1 -> m_data 0x00..0x81 in order, empty=1.
//  3 Single push 0xA5 in cycle N on empty -> mem_rd_en N+1, m_valid N+3, m_data=0xA5.
//  4 Continuous push+pop 300 words -> 1 word/cycle after latency, wr/rd_ptr
//    wrap 127->0 twice, data sequence intact, level constant.
//  5 Random s_valid/m_ready 50% for 5000 words -> scoreboard match, level
//    equals model each cycle, no RAM read of an unwritten address.
//  6 rst asserted with level=60 and read in flight -> next cycle level=0,
//    m_valid=0; returning mem_rdata ignored; post-reset push 0x11 emerges first.

Source files
------------

// File: rtl/dual_port_pkg.sv
// Shared sizing defaults for the dual_port RAM and the controller that drives it.
package dual_port_pkg;

    localparam int DP_WIDTH     = 8;
    localparam int DP_DEPTH     = 128;
    localparam int DP_ADD_WIDTH = 7;
    localparam int DP_LVL_W     = DP_ADD_WIDTH + 2;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order buffer. slot0 is always the oldest word (the head), so
// the consumer sees registered data without any read-side muxing.
module fifo_out_buf
    import dual_port_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       cnt,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    // Storage and occupancy; a simultaneous push and pop keeps arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/dual_port_fifo_ctrl.sv
// FIFO controller for a dual_port RAM with a 1-cycle registered read.
// Handshakes: a word moves on a port exactly in a cycle where valid && ready
// are both high at the rising edge; valid never depends on ready.
module dual_port_fifo_ctrl
    import dual_port_pkg::*;
#(
    parameter int WIDTH     = DP_WIDTH,
    parameter int DEPTH     = DP_DEPTH,
    parameter int ADD_WIDTH = DP_ADD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 mem_wr_en,
    output logic [ADD_WIDTH-1:0] mem_wr_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_rd_en,
    output logic [ADD_WIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic [ADD_WIDTH+1:0] level,
    output logic                 full,
    output logic                 empty
);

    localparam int LVL_W     = ADD_WIDTH + 2;
    localparam int LVL_MAX_I = DEPTH + 2;
    localparam logic [ADD_WIDTH:0] MEM_FULL = DEPTH[ADD_WIDTH:0];
    localparam logic [LVL_W-1:0]   LVL_MAX  = LVL_MAX_I[LVL_W-1:0];

    logic [ADD_WIDTH-1:0] wr_ptr;
    logic [ADD_WIDTH-1:0] rd_ptr;
    logic [ADD_WIDTH:0]   mem_cnt;   // committed words sitting in the RAM
    logic                 inflight;  // a RAM read returns data this cycle
    logic [1:0]           out_cnt;
    logic [1:0]           out_after_pop;
    logic [WIDTH-1:0]     out_head;
    logic                 push;
    logic                 pop;
    logic                 rd_issue;

    assign s_ready = !rst && (mem_cnt < MEM_FULL);
    assign push    = s_valid && s_ready;
    assign m_valid = (out_cnt != 2'd0);
    assign m_data  = out_head;
    assign pop     = m_valid && m_ready;

    // Read-issue decision: only committed words, and never more than the two
    // buffer slots can hold once this cycle's pop and return are accounted for.
    always_comb begin
        out_after_pop = out_cnt - {1'b0, pop};
        rd_issue      = 1'b0;
        if (!rst && (mem_cnt != '0) &&
            ((out_after_pop + {1'b0, inflight}) < 2'd2)) begin
            rd_issue = 1'b1;
        end
    end

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr;
    assign mem_wdata   = s_data;
    assign mem_rd_en   = rd_issue;
    assign mem_rd_addr = rd_ptr;

    // Pointers, RAM occupancy and the in-flight read marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, rd_issue})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_issue;
        end
    end

    // Total words held, counted at the two streaming ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign full  = (level == LVL_MAX);
    assign empty = (level == '0);

    fifo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (mem_rdata),
        .cnt  (out_cnt),
        .head (out_head)
    );

endmodule
